ex_mem_stage_reg: RTL and testbench
===================================

Name: ex_mem_stage_reg

Overview:
Parametrised EX/MEM pipeline stage register with valid/ready handshake, synchronous flush and bubble gating of control bits. It replaces the fixed-width EX/MEM register and sits between ALU/forwarding mux output and the data-memory stage. It carries the destination register address, ALU result, store data and a generic control vector. Downstream back-pressure (data-memory wait) stalls EX without dropping an instruction.

Parameters:
DATA_W, 32, width of ALU result and store data
ADDR_W, 5, destination register address width
CTRL_W, 4, control vector width; bit0 reg_write_en, bit1 wbsel, bit2 mem_read, bit3 mem_write

Ports:
clk  in  1  clock, all state updates on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
flush  in  1  synchronous kill of all held and incoming instructions
in_valid  in  1  EX presents an instruction
in_ready  out  1  stage can accept this cycle
in_write_addr  in  ADDR_W  destination register
in_alu_result  in  DATA_W  ALU/mux result
in_store_data  in  DATA_W  rs2 data for stores
in_ctrl  in  CTRL_W  control vector
out_valid  out  1  MEM stage instruction valid
out_ready  in  1  MEM stage accepts this cycle
out_write_addr  out  ADDR_W
out_alu_result  out  DATA_W
out_store_data  out  DATA_W
out_ctrl  out  CTRL_W  gated: all-zero whenever out_valid=0

Behaviour:
- Transfer occurs on an edge where valid&ready are both 1 on that side. Nothing else moves data.
- Reset (reset=0, asynchronous): out_valid=0, in_ready=1 (skid build) or 1 (non-skid, out_valid=0), all payload registers 0, skid register empty. Reset mid-transfer discards everything; first accept is possible on the first edge after deassertion.
- Latency: 1 cycle. An instruction accepted at edge N appears on out_* after edge N.
- State machine (skid build): EMPTY (no valid), FULL (main valid), SKID (main and skid valid).
  - EMPTY: accept -> FULL.
  - FULL: accept & !drain -> SKID (input goes to skid). accept & drain -> FULL (main reloaded). !accept & drain -> EMPTY.
  - SKID: drain -> FULL (skid moves to main). in_ready=0.
- in_ready (skid build) = !skid_valid. This is a registered signal with no combinational path from out_ready.
- Data ordering is strictly FIFO. No instruction is duplicated or dropped except by flush.
- Flush: on an edge with flush=1, main and skid valid bits clear and the state goes to EMPTY. An instruction accepted in the same cycle is discarded. Flush has priority over accept and drain. Payload data registers may retain stale values. out_ctrl reads 0 because of gating.
- Bubble: when no instruction is accepted, the valid bit drops. Data fields hold their last value and ctrl is gated to 0, so there is never a spurious reg or mem write.
- out_* held stable while out_valid=1 and out_ready=0.

Optional Feature:
EX_MEM_SKID_EN.
- Defined: 2-entry skid buffer as above. in_ready is registered, and full throughput is kept under back-pressure.
- Undefined: single register with states EMPTY and FULL only. in_ready = !out_valid | out_ready, which is combinational from out_ready. Flush and reset behaviour are identical, and the port list is unchanged.

Decomposition:
- Shared package riscv_pipe_pkg holds:
  - CTRL bit index constants (CTRL_REG_WE=0, CTRL_WBSEL=1, CTRL_MEM_RD=2, CTRL_MEM_WR=3).
  - Default widths.
  - Reset-value constants.
- One natural sub-module is pipe_payload_reg: a parametrised W-bit load-enable register with async active-low clear. It is instantiated for the main and skid payloads. Handshake and state logic stay in the top module.

Test Plan:
- Reset: hold reset=0 with in_valid=1 and in_ctrl=4'hF -> out_valid=0, out_ctrl=0 and all outputs 0. After release, the first accepted word appears 1 cycle later.
- Streaming: out_ready=1, push 8 instructions with alu_result 0x10..0x17 -> outputs in order with 1-cycle latency, no gaps, in_ready constantly 1.
- Back-pressure (skid build): out_ready=0 for 3 cycles during a stream -> exactly 2 instructions held, in_ready=0 from the 2nd stalled edge, out_* stable. On release, 0x12 then 0x13 follow with no loss.
- Flush: SKID state holding 0x20/0x21, assert flush with in_valid=1 (0x22) -> next cycle out_valid=0, out_ctrl=0, in_ready=1, and 0x22 is never output.
- Bubble gating: in_valid=0 after a store (ctrl=4'b1000) -> out_valid=0 and out_ctrl=4'b0000 while out_alu_result keeps the last value.
- Non-skid build: out_ready=0 with out_valid=1 -> in_ready=0 in the same cycle. out_ready=1 -> in_ready=1 combinationally and back-to-back transfer works.

Source files
------------

// File: rtl/riscv_pipe_pkg.sv
// Shared pipeline definitions: control-vector bit indices, default widths, reset values.
// Holds no logic; it is imported by the pipeline stage registers.
package riscv_pipe_pkg;

  localparam int DATA_W_DEF = 32;
  localparam int ADDR_W_DEF = 5;
  localparam int CTRL_W_DEF = 4;

  localparam int CTRL_REG_WE = 0;
  localparam int CTRL_WBSEL  = 1;
  localparam int CTRL_MEM_RD = 2;
  localparam int CTRL_MEM_WR = 3;

  localparam logic RST_VALID = 1'b0;
  localparam logic RST_READY = 1'b1;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_t;

endpackage

// File: rtl/pipe_payload_reg.sv
// W-bit load-enable payload register, async active-low clear; 1-cycle latency, no handshake.
module pipe_payload_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)    q <= '0;
    else if (load) q <= d;
  end

endmodule

// File: rtl/ex_mem_stage_reg.sv
// EX/MEM stage register, 1-cycle latency, valid/ready with flush and ctrl gating on bubbles.
// EX_MEM_SKID_EN: 2-entry skid with registered in_ready; otherwise in_ready follows out_ready.
module ex_mem_stage_reg
  import riscv_pipe_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int CTRL_W = CTRL_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] in_write_addr,
  input  logic [DATA_W-1:0] in_alu_result,
  input  logic [DATA_W-1:0] in_store_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] out_write_addr,
  output logic [DATA_W-1:0] out_alu_result,
  output logic [DATA_W-1:0] out_store_data,
  output logic [CTRL_W-1:0] out_ctrl
);

  localparam int PW = ADDR_W + 2 * DATA_W + CTRL_W;

  logic [PW-1:0]     in_pay;
  logic [PW-1:0]     main_d;
  logic [PW-1:0]     main_q;
  logic              main_load;
  logic              main_valid;
  logic              accept;
  logic              drain;
  logic [CTRL_W-1:0] ctrl_raw;

  assign in_pay = {in_write_addr, in_alu_result, in_store_data, in_ctrl};
  assign accept = in_valid & in_ready;
  assign drain  = main_valid & out_ready;

`ifdef EX_MEM_SKID_EN
  stage_state_t  state;
  logic [PW-1:0] skid_q;
  logic          skid_load;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= ST_EMPTY;
    end else if (flush) begin
      state <= ST_EMPTY;
    end else begin
      case (state)
        ST_EMPTY: if (accept) state <= ST_FULL;
        ST_FULL: begin
          if (accept && !drain)      state <= ST_SKID;
          else if (!accept && drain) state <= ST_EMPTY;
        end
        ST_SKID:  if (drain) state <= ST_FULL;
        default:  state <= ST_EMPTY;
      endcase
    end
  end

  // in_ready decodes only the state flops, so out_ready never reaches it combinationally.
  assign in_ready   = (state != ST_SKID);
  assign main_valid = (state != ST_EMPTY);
  assign main_load  = ((state == ST_EMPTY) && accept) ||
                      ((state == ST_FULL) && accept && drain) ||
                      ((state == ST_SKID) && drain);
  assign main_d     = (state == ST_SKID) ? skid_q : in_pay;
  assign skid_load  = (state == ST_FULL) && accept && !drain;

  pipe_payload_reg #(.W(PW)) u_skid (
    .clk   (clk),
    .reset (reset),
    .load  (skid_load),
    .d     (in_pay),
    .q     (skid_q)
  );
`else
  logic valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      valid_q <= RST_VALID;
    else if (flush)  valid_q <= 1'b0;
    else if (accept) valid_q <= 1'b1;
    else if (drain)  valid_q <= 1'b0;
  end

  assign main_valid = valid_q;
  assign in_ready   = !valid_q | out_ready;
  assign main_load  = accept;
  assign main_d     = in_pay;
`endif

  pipe_payload_reg #(.W(PW)) u_main (
    .clk   (clk),
    .reset (reset),
    .load  (main_load),
    .d     (main_d),
    .q     (main_q)
  );

  assign {out_write_addr, out_alu_result, out_store_data, ctrl_raw} = main_q;
  assign out_valid = main_valid;
  // Stale payload may linger after a bubble or flush; gating ctrl prevents phantom writes.
  assign out_ctrl  = main_valid ? ctrl_raw : '0;

endmodule

// File: tb/tb_ex_mem_stage_reg.sv
// Directed table-driven bench for ex_mem_stage_reg; expectations follow whichever build is compiled.
module tb_ex_mem_stage_reg;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_write_addr;
  logic [31:0] in_alu_result;
  logic [31:0] in_store_data;
  logic [3:0]  in_ctrl;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_write_addr;
  logic [31:0] out_alu_result;
  logic [31:0] out_store_data;
  logic [3:0]  out_ctrl;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ex_mem_stage_reg dut (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_write_addr  (in_write_addr),
    .in_alu_result  (in_alu_result),
    .in_store_data  (in_store_data),
    .in_ctrl        (in_ctrl),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_write_addr (out_write_addr),
    .out_alu_result (out_alu_result),
    .out_store_data (out_store_data),
    .out_ctrl       (out_ctrl)
  );

  typedef struct {
    logic        iv;
    logic        ordy;
    logic        fl;
    logic [31:0] alu;
    logic [3:0]  ctrl;
    logic        exp_ir;
    logic        exp_ov;
    logic        chk;
    logic [31:0] exp_alu;
    logic [3:0]  exp_ctrl;
  } vec_t;

  vec_t tbl [15];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Apply one cycle: in_ready is checked before the edge, registered outputs after it.
  task automatic drive(input string nm, input logic iv, input logic ordy, input logic fl,
                       input logic [31:0] alu, input logic [3:0] ctrl, input logic exp_ir,
                       input logic exp_ov, input logic chk, input logic [31:0] exp_alu,
                       input logic [3:0] exp_ctrl);
    in_valid      = iv;
    out_ready     = ordy;
    flush         = fl;
    in_alu_result = alu;
    in_write_addr = alu[4:0];
    in_store_data = alu ^ 32'hA5A5_0000;
    in_ctrl       = ctrl;
    #1;
    check({nm, ".in_ready"}, {31'd0, in_ready}, {31'd0, exp_ir});
    @(posedge clk);
    #1;
    check({nm, ".out_valid"}, {31'd0, out_valid}, {31'd0, exp_ov});
    check({nm, ".out_ctrl"}, {28'd0, out_ctrl}, {28'd0, exp_ctrl});
    if (chk) begin
      check({nm, ".out_alu"}, out_alu_result, exp_alu);
      check({nm, ".out_waddr"}, {27'd0, out_write_addr}, {27'd0, exp_alu[4:0]});
      check({nm, ".out_store"}, out_store_data, exp_alu ^ 32'hA5A5_0000);
    end
  endtask

  initial begin
    for (int i = 0; i < 8; i++)
      tbl[i] = '{1'b1, 1'b1, 1'b0, 32'h10 + i, 4'b0001, 1'b1, 1'b1, 1'b1, 32'h10 + i, 4'b0001};
    tbl[8]  = '{1'b1, 1'b1, 1'b0, 32'h30, 4'b1000, 1'b1, 1'b1, 1'b1, 32'h30, 4'b1000};
    tbl[9]  = '{1'b0, 1'b1, 1'b0, 32'h99, 4'b1000, 1'b1, 1'b0, 1'b1, 32'h30, 4'b0000};
    tbl[10] = '{1'b0, 1'b1, 1'b0, 32'h98, 4'b1111, 1'b1, 1'b0, 1'b1, 32'h30, 4'b0000};
    tbl[11] = '{1'b1, 1'b1, 1'b1, 32'h40, 4'b0001, 1'b1, 1'b0, 1'b0, 32'h0,  4'b0000};
    tbl[12] = '{1'b1, 1'b1, 1'b0, 32'h41, 4'b0101, 1'b1, 1'b1, 1'b1, 32'h41, 4'b0101};
    tbl[13] = '{1'b0, 1'b1, 1'b1, 32'h0,  4'b0000, 1'b1, 1'b0, 1'b0, 32'h0,  4'b0000};
    tbl[14] = '{1'b1, 1'b1, 1'b0, 32'h42, 4'b0010, 1'b1, 1'b1, 1'b1, 32'h42, 4'b0010};

    reset         = 1'b0;
    flush         = 1'b0;
    in_valid      = 1'b1;
    out_ready     = 1'b1;
    in_ctrl       = 4'hF;
    in_alu_result = 32'hDEAD_BEEF;
    in_write_addr = 5'h1F;
    in_store_data = 32'hFFFF_FFFF;
    repeat (3) @(posedge clk);
    #1;
    check("rst.out_valid", {31'd0, out_valid}, 32'd0);
    check("rst.out_ctrl", {28'd0, out_ctrl}, 32'd0);
    check("rst.out_alu", out_alu_result, 32'd0);
    check("rst.out_store", out_store_data, 32'd0);
    check("rst.out_waddr", {27'd0, out_write_addr}, 32'd0);
    check("rst.in_ready", {31'd0, in_ready}, 32'd1);
    reset = 1'b1;

    for (int i = 0; i < 15; i++)
      drive($sformatf("vec%0d", i), tbl[i].iv, tbl[i].ordy, tbl[i].fl, tbl[i].alu, tbl[i].ctrl,
            tbl[i].exp_ir, tbl[i].exp_ov, tbl[i].chk, tbl[i].exp_alu, tbl[i].exp_ctrl);

`ifdef EX_MEM_SKID_EN
    drive("bp0", 1, 1, 0, 32'h10, 4'd1, 1, 1, 1, 32'h10, 4'd1);
    drive("bp1", 1, 1, 0, 32'h11, 4'd1, 1, 1, 1, 32'h11, 4'd1);
    drive("stall1", 1, 0, 0, 32'h12, 4'd1, 1, 1, 1, 32'h11, 4'd1);
    drive("stall2", 1, 0, 0, 32'h13, 4'd1, 0, 1, 1, 32'h11, 4'd1);
    drive("stall3", 1, 0, 0, 32'h13, 4'd1, 0, 1, 1, 32'h11, 4'd1);
    drive("rel0", 1, 1, 0, 32'h13, 4'd1, 0, 1, 1, 32'h12, 4'd1);
    drive("rel1", 1, 1, 0, 32'h13, 4'd1, 1, 1, 1, 32'h13, 4'd1);
    drive("rel2", 0, 1, 0, 32'h0, 4'd0, 1, 0, 1, 32'h13, 4'd0);
    drive("fl_fill0", 1, 0, 0, 32'h20, 4'd1, 1, 1, 1, 32'h20, 4'd1);
    drive("fl_fill1", 1, 0, 0, 32'h21, 4'd1, 1, 1, 1, 32'h20, 4'd1);
    drive("fl_kill", 1, 0, 1, 32'h22, 4'd1, 0, 0, 0, 32'h0, 4'd0);
    check("fl_kill.in_ready_after", {31'd0, in_ready}, 32'd1);
    drive("fl_after", 0, 1, 0, 32'h0, 4'd0, 1, 0, 0, 32'h0, 4'd0);
`else
    drive("ns_hold", 1, 0, 0, 32'h50, 4'd2, 0, 1, 1, 32'h42, 4'd2);
    drive("ns_go0", 1, 1, 0, 32'h50, 4'd2, 1, 1, 1, 32'h50, 4'd2);
    drive("ns_go1", 1, 1, 0, 32'h51, 4'd4, 1, 1, 1, 32'h51, 4'd4);
    drive("ns_idle", 0, 1, 0, 32'h0, 4'd0, 1, 0, 1, 32'h51, 4'd0);
    drive("ns_fl0", 1, 1, 0, 32'h60, 4'd1, 1, 1, 1, 32'h60, 4'd1);
    drive("ns_fl1", 1, 1, 1, 32'h61, 4'd1, 1, 0, 0, 32'h0, 4'd0);
    drive("ns_fl2", 0, 1, 0, 32'h0, 4'd0, 1, 0, 0, 32'h0, 4'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
